// File: rtl/noc_axilite_req_arbiter.sv
// rtl/noc_axilite_req_arbiter.sv - AXI-lite read/write to NoC request arbiter with outstanding tracking
module noc_axilite_req_arbiter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 16,
    parameter int HALF_SEL_BIT    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [1:0]              req_type,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_data,
    output logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    transaction_type_wr,
    output logic [2:0]              transaction_type_wr_data,
    input  logic                    rsp_done,
    output logic [4:0]              outstanding,
    output logic                    err_underflow
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_LOAD  = 2'd1;
    localparam logic [1:0] TYPE_STORE = 2'd2;
    localparam logic [4:0] MAX_OUT    = 5'(MAX_OUTSTANDING);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_type;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [4:0]              r_outstanding;
    logic                    r_err_underflow;
    logic                    r_last_wr;

    logic w_has_room;
    logic w_rd_elig;
    logic w_wr_elig;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_req_fire;
    logic w_dec;

    // Eligibility looks only at the registered count, so a same-cycle rsp_done cannot open a full slot.
    assign w_has_room = (r_outstanding < MAX_OUT);
    assign w_rd_elig  = (r_state == S_IDLE) && s_axi_arvalid && w_has_room;
    assign w_wr_elig  = (r_state == S_IDLE) && s_axi_awvalid && s_axi_wvalid && w_has_room;
    assign w_req_fire = (r_state == S_ISSUE) && req_ready;
    assign w_dec      = rsp_done && (r_outstanding != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_rd    = 1'b0;
        w_grant_wr    = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        req_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_rd    = w_rd_elig && (!w_wr_elig || r_last_wr);
                w_grant_wr    = w_wr_elig && !w_grant_rd;
                s_axi_arready = w_grant_rd;
                s_axi_awready = w_grant_wr;
                s_axi_wready  = w_grant_wr;
                if (w_grant_rd || w_grant_wr) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type    <= 2'd0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
            r_last_wr <= 1'b1;
        end else if (w_grant_rd) begin
            r_type <= TYPE_LOAD;
            r_addr <= s_axi_araddr;
            r_data <= '0;
            r_strb <= '0;
        end else if (w_grant_wr) begin
            r_type <= TYPE_STORE;
            r_addr <= s_axi_awaddr;
            r_data <= s_axi_wdata;
            r_strb <= s_axi_wstrb;
        end else if (w_req_fire) begin
            r_last_wr <= (r_type == TYPE_STORE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding   <= 5'd0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_req_fire && !w_dec) begin
                r_outstanding <= r_outstanding + 5'd1;
            end else if (!w_req_fire && w_dec) begin
                r_outstanding <= r_outstanding - 5'd1;
            end
            if (rsp_done && (r_outstanding == 5'd0)) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign req_type                 = r_type;
    assign req_addr                 = r_addr;
    assign req_data                 = r_data;
    assign req_strb                 = r_strb;
    assign transaction_type_wr      = w_req_fire;
    assign transaction_type_wr_data = {r_type, r_addr[HALF_SEL_BIT]};
    assign outstanding              = r_outstanding;
    assign err_underflow            = r_err_underflow;

endmodule

// File: tb/tb_noc_axilite_req_arbiter.sv
// tb/tb_noc_axilite_req_arbiter.sv - self-checking bench for noc_axilite_req_arbiter
module tb_noc_axilite_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int MAXO = 16;
    localparam int HSB = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_type;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [SW-1:0] req_strb;
    logic          ttw;
    logic [2:0]    ttw_data;
    logic          rsp_done;
    logic [4:0]    outstanding;
    logic          err_underflow;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    noc_axilite_req_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .HALF_SEL_BIT(HSB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .transaction_type_wr(ttw), .transaction_type_wr_data(ttw_data),
        .rsp_done(rsp_done), .outstanding(outstanding), .err_underflow(err_underflow)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: an arbiter holds at most one request; grants follow the eligibility and
    // alternation rules, and a separate in-flight count moves on issue and on responses.
    logic          m_busy, m_last_wr, m_err;
    int            m_cnt;
    logic [1:0]    m_type;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic          e_rd_ok, e_wr_ok, e_pick_rd, e_pick_wr, e_fire;

    always_comb begin
        e_rd_ok   = !m_busy && arvalid && (m_cnt < MAXO);
        e_wr_ok   = !m_busy && awvalid && wvalid && (m_cnt < MAXO);
        e_pick_rd = e_rd_ok && (!e_wr_ok || m_last_wr);
        e_pick_wr = e_wr_ok && !e_pick_rd;
        e_fire    = m_busy && req_ready;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_last_wr <= 1'b1; m_err <= 1'b0; m_cnt <= 0;
            m_type <= '0; m_addr <= '0; m_data <= '0; m_strb <= '0;
        end else begin
            if (e_pick_rd) begin
                m_busy <= 1'b1; m_type <= 2'd1; m_addr <= araddr; m_data <= '0; m_strb <= '0;
            end else if (e_pick_wr) begin
                m_busy <= 1'b1; m_type <= 2'd2; m_addr <= awaddr; m_data <= wdata; m_strb <= wstrb;
            end else if (e_fire) begin
                m_busy <= 1'b0; m_last_wr <= (m_type == 2'd2);
            end
            m_cnt <= m_cnt + (e_fire ? 1 : 0) - ((rsp_done && m_cnt > 0) ? 1 : 0);
            if (rsp_done && m_cnt == 0) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon.arready", 64'(arready), 64'(e_pick_rd));
            chk("mon.awready", 64'(awready), 64'(e_pick_wr));
            chk("mon.wready", 64'(wready), 64'(e_pick_wr));
            chk("mon.req_valid", 64'(req_valid), 64'(m_busy));
            chk("mon.ttw", 64'(ttw), 64'(e_fire));
            chk("mon.outstanding", 64'(outstanding), 64'(m_cnt));
            chk("mon.err_underflow", 64'(err_underflow), 64'(m_err));
            chk("mon.bound", 64'(outstanding <= 5'(MAXO)), 64'd1);
            if (m_busy) begin
                chk("mon.req_type", 64'(req_type), 64'(m_type));
                chk("mon.req_addr", 64'(req_addr), 64'(m_addr));
                chk("mon.req_data", 64'(req_data), 64'(m_data));
                chk("mon.req_strb", 64'(req_strb), 64'(m_strb));
            end
            if (e_fire) chk("mon.ttw_data", 64'(ttw_data), 64'({m_type, m_addr[HSB]}));
        end
    end

    typedef struct {
        logic [4:0] in;     // {arvalid, awvalid, wvalid, req_ready, rsp_done}
        logic [2:0] ex;     // {arready, awready, req_valid}
        logic [1:0] e_type;
        logic [4:0] e_out;
        logic       e_err;
    } vec_t;

    vec_t tbl[15];

    task automatic idle_inputs();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; req_ready = 1'b0; rsp_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{5'b11110, 3'b100, 2'd0, 5'd0, 1'b0};
        tbl[1]  = '{5'b11110, 3'b001, 2'd1, 5'd0, 1'b0};
        tbl[2]  = '{5'b11110, 3'b010, 2'd0, 5'd1, 1'b0};
        tbl[3]  = '{5'b11110, 3'b001, 2'd2, 5'd1, 1'b0};
        tbl[4]  = '{5'b11110, 3'b100, 2'd0, 5'd2, 1'b0};
        tbl[5]  = '{5'b11110, 3'b001, 2'd1, 5'd2, 1'b0};
        tbl[6]  = '{5'b11110, 3'b010, 2'd0, 5'd3, 1'b0};
        tbl[7]  = '{5'b11110, 3'b001, 2'd2, 5'd3, 1'b0};
        tbl[8]  = '{5'b10011, 3'b100, 2'd0, 5'd4, 1'b0};
        tbl[9]  = '{5'b00011, 3'b001, 2'd1, 5'd3, 1'b0};
        tbl[10] = '{5'b00011, 3'b000, 2'd0, 5'd3, 1'b0};
        tbl[11] = '{5'b00011, 3'b000, 2'd0, 5'd2, 1'b0};
        tbl[12] = '{5'b00011, 3'b000, 2'd0, 5'd1, 1'b0};
        tbl[13] = '{5'b00011, 3'b000, 2'd0, 5'd0, 1'b0};
        tbl[14] = '{5'b00010, 3'b000, 2'd0, 5'd0, 1'b1};

        araddr = 32'h0000_0040; awaddr = 32'h1000_0080;
        wdata = 64'hDEAD_BEEF_0123_4567; wstrb = 8'hF0;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst.req_valid", 64'(req_valid), 64'd0);
        chk("rst.arready", 64'(arready), 64'd0);
        chk("rst.req_type", 64'(req_type), 64'd0);
        chk("rst.req_addr", 64'(req_addr), 64'd0);
        chk("rst.ttw_data", 64'(ttw_data), 64'd0);
        chk("rst.outstanding", 64'(outstanding), 64'd0);
        chk("rst.err", 64'(err_underflow), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Alternating grants, simultaneous issue and response, then underflow.
        for (int i = 0; i < 15; i++) begin
            cyc();
            {arvalid, awvalid, wvalid, req_ready, rsp_done} = tbl[i].in;
            @(negedge clk);
            chk($sformatf("tbl%0d.arready", i), 64'(arready), 64'(tbl[i].ex[2]));
            chk($sformatf("tbl%0d.awready", i), 64'(awready), 64'(tbl[i].ex[1]));
            chk($sformatf("tbl%0d.wready", i), 64'(wready), 64'(tbl[i].ex[1]));
            chk($sformatf("tbl%0d.req_valid", i), 64'(req_valid), 64'(tbl[i].ex[0]));
            if (tbl[i].ex[0]) chk($sformatf("tbl%0d.req_type", i), 64'(req_type), 64'(tbl[i].e_type));
            chk($sformatf("tbl%0d.outstanding", i), 64'(outstanding), 64'(tbl[i].e_out));
            chk($sformatf("tbl%0d.err", i), 64'(err_underflow), 64'(tbl[i].e_err));
        end

        // Single read of 0x40.
        do_reset();
        cyc();
        araddr = 32'h0000_0040; arvalid = 1'b1; req_ready = 1'b1;
        @(negedge clk);
        chk("rd1.arready", 64'(arready), 64'd1);
        cyc();
        arvalid = 1'b0;
        @(negedge clk);
        chk("rd1.req_valid", 64'(req_valid), 64'd1);
        chk("rd1.req_type", 64'(req_type), 64'd1);
        chk("rd1.ttw_data", 64'(ttw_data), 64'b011);
        chk("rd1.arready_once", 64'(arready), 64'd0);
        cyc();
        @(negedge clk);
        chk("rd1.outstanding", 64'(outstanding), 64'd1);

        // aw without w is never accepted.
        do_reset();
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("aw_only%0d.awready", i), 64'(awready), 64'd0);
            chk($sformatf("aw_only%0d.wready", i), 64'(wready), 64'd0);
        end
        cyc();
        wvalid = 1'b1;
        @(negedge clk);
        chk("aw_w.awready", 64'(awready), 64'd1);
        chk("aw_w.wready", 64'(wready), 64'd1);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; req_ready = 1'b1;

        // Fill to the limit, then one response re-opens a slot a cycle later.
        do_reset();
        begin
            bit full = 1'b0;
            arvalid = 1'b1; req_ready = 1'b1;
            for (int k = 0; k < 40 && !full; k++) begin
                cyc();
                @(negedge clk);
                if (outstanding == 5'd16) full = 1'b1;
            end
            chk("full.reached", 64'(full), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("full%0d.arready", i), 64'(arready), 64'd0);
            chk($sformatf("full%0d.outstanding", i), 64'(outstanding), 64'd16);
        end
        cyc();
        rsp_done = 1'b1;
        @(negedge clk);
        chk("full_rsp.arready", 64'(arready), 64'd0);
        cyc();
        rsp_done = 1'b0;
        @(negedge clk);
        chk("after_rsp.outstanding", 64'(outstanding), 64'd15);
        chk("after_rsp.arready", 64'(arready), 64'd1);
        cyc();
        arvalid = 1'b0;

        // Reset while a request is stalled discards it.
        do_reset();
        cyc();
        awvalid = 1'b1; wvalid = 1'b1; req_ready = 1'b0;
        @(negedge clk);
        chk("stall.awready", 64'(awready), 64'd1);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("stall.req_valid", 64'(req_valid), 64'd1);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.req_valid", 64'(req_valid), 64'd0);
        chk("rst_mid.ttw", 64'(ttw), 64'd0);
        chk("rst_mid.outstanding", 64'(outstanding), 64'd0);
        chk("rst_mid.req_addr", 64'(req_addr), 64'd0);
        arvalid = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst.arready", 64'(arready), 64'd1);
        cyc();
        arvalid = 1'b0;
        @(negedge clk);
        chk("post_rst.req_valid", 64'(req_valid), 64'd1);
        chk("post_rst.req_type", 64'(req_type), 64'd1);
        chk("post_rst.outstanding", 64'(outstanding), 64'd0);
        cyc();
        req_ready = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            arvalid   = 1'($urandom_range(0, 1));
            awvalid   = 1'($urandom_range(0, 1));
            wvalid    = 1'($urandom_range(0, 3) != 0);
            req_ready = 1'($urandom_range(0, 9) < 7);
            rsp_done  = 1'($urandom_range(0, 9) < ((i % 1000) < 500 ? 1 : 6));
            araddr    = $urandom;
            awaddr    = $urandom;
            wdata     = {$urandom, $urandom};
            wstrb     = 8'($urandom);
        end
        cyc();
        idle_inputs();
        @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
